// File: rtl/maxnet_loader_if.sv
// Upstream word stream for the MaxNet loader.
//   in_valid : source has a word on in_data
//   in_data  : DW-bit word (X0..X3, then W0..W15)
//   in_ready : loader can accept a word this cycle
// master = upstream source, slave = maxnet_loader.
interface maxnet_loader_if #(
    parameter int DW = 32
) ();
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/maxnet_loader.sv
// Load stage for the 4-neuron MaxNet datapath.
// Collects NX activation words then NW weight words from a valid/ready
// stream, presents them on x_bus/w_bus, pulses start, waits for done and
// captures the winner from res_in.
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   in_if        upstream stream (slave modport: in_valid/in_data/in_ready)
//   x_bus        NX words, X0 in [DW-1:0]
//   w_bus        NW words, W0 in [DW-1:0] (NW must equal NX*NX)
//   start        one-cycle pulse to the MaxNet controller
//   done         is_finished from the datapath
//   res_in       winner value from the datapath
//   result       captured winner
//   result_valid one-cycle pulse when result updates
//   busy         high from START through the capture edge
module maxnet_loader #(
    parameter int DW = 32,
    parameter int NX = 4,
    parameter int NW = 16
) (
    input  logic               clk,
    input  logic               rst,
    maxnet_loader_if.slave     in_if,
    output logic [NX*DW-1:0]   x_bus,
    output logic [NW*DW-1:0]   w_bus,
    output logic               start,
    input  logic               done,
    input  logic [DW-1:0]      res_in,
    output logic [DW-1:0]      result,
    output logic               result_valid,
    output logic               busy
);

    localparam int          CW   = $clog2(NX + NW);
    localparam logic [CW-1:0] LAST = CW'(NX + NW - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_START,
        S_SETTLE,
        S_BUSY
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NX*DW-1:0]  x_q, x_d;
    logic [NW*DW-1:0]  w_q, w_d;
    logic [DW-1:0]     result_q, result_d;
    logic              result_valid_q, result_valid_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              in_ready;

    // Ready is decoded straight from state so it is high right out of reset.
    assign in_ready       = (state_q == S_LOAD);
    assign in_if.in_ready = in_ready;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        x_d            = x_q;
        w_d            = w_q;
        result_d       = result_q;
        result_valid_d = 1'b0;

        case (state_q)
            S_LOAD: begin
                if (in_if.in_valid && in_ready) begin
                    for (int unsigned i = 0; i < NX; i++) begin
                        if (cnt_q == CW'(i)) x_d[i*DW +: DW] = in_if.in_data;
                    end
                    for (int unsigned i = 0; i < NW; i++) begin
                        if (cnt_q == CW'(NX + i)) w_d[i*DW +: DW] = in_if.in_data;
                    end
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = S_START;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_START:  state_d = S_SETTLE;
            // Datapath loads its neuron registers here; done is not trusted yet.
            S_SETTLE: state_d = S_BUSY;
            S_BUSY: begin
                if (done) begin
                    result_d       = res_in;
                    result_valid_d = 1'b1;
                    state_d        = S_LOAD;
                end
            end
            default:  state_d = S_LOAD;
        endcase

        // start/busy are registered from the next state so they line up
        // exactly with the START..BUSY residency.
        start_d = (state_d == S_START);
        busy_d  = (state_d != S_LOAD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_LOAD;
            cnt_q          <= '0;
            x_q            <= '0;
            w_q            <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            start_q        <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            x_q            <= x_d;
            w_q            <= w_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            start_q        <= start_d;
            busy_q         <= busy_d;
        end
    end

    assign x_bus        = x_q;
    assign w_bus        = w_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign start        = start_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_maxnet_loader.sv
module tb_maxnet_loader;

    localparam int DW = 32;
    localparam int NX = 4;
    localparam int NW = 16;

    logic              clk;
    logic              rst_n;
    logic [NX*DW-1:0]  x_bus;
    logic [NW*DW-1:0]  w_bus;
    logic              start;
    logic              done;
    logic [DW-1:0]     res_in;
    logic [DW-1:0]     result;
    logic              result_valid;
    logic              busy;

    maxnet_loader_if #(.DW(DW)) bus ();

    maxnet_loader #(.DW(DW), .NX(NX), .NW(NW)) dut (
        .clk          (clk),
        .rst          (rst_n),
        .in_if        (bus),
        .x_bus        (x_bus),
        .w_bus        (w_bus),
        .start        (start),
        .done         (done),
        .res_in       (res_in),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int start_cnt = 0;
    int s0;

    always @(negedge clk) if (start === 1'b1) start_cnt++;

    logic [NX*DW-1:0] exp_x;
    logic [NW*DW-1:0] exp_w;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < NX; i++) exp_x[i*DW +: DW] = DW'(i + 1);
        for (int i = 0; i < NW; i++) exp_w[i*DW +: DW] = DW'(i + 5);

        // Reset held with in_valid high: nothing consumed.
        rst_n = 1'b0; bus.in_valid = 1'b1; bus.in_data = 32'h55; done = 1'b0; res_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 512'(bus.in_ready), 512'(1));
        chk("rst_x_bus", 512'(x_bus), 512'(0));
        chk("rst_w_bus", 512'(w_bus), 512'(0));
        chk("rst_start", 512'(start), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_result", 512'(result), 512'(0));
        rst_n = 1'b1; bus.in_valid = 1'b0;
        step();
        chk("post_rst_x_bus", 512'(x_bus), 512'(0));

        // Back-to-back load of words 1..20.
        s0 = start_cnt;
        for (int k = 1; k <= 20; k++) begin
            bus.in_valid = 1'b1; bus.in_data = DW'(k);
            step();
        end
        chk("full_start", 512'(start), 512'(1));
        chk("full_busy", 512'(busy), 512'(1));
        chk("full_in_ready", 512'(bus.in_ready), 512'(0));
        chk("full_x_bus", 512'(x_bus), 512'(exp_x));
        chk("full_w_bus", 512'(w_bus), 512'(exp_w));

        // done held high from START onward; must wait until BUSY.
        done = 1'b1; res_in = 32'h0000_0007; bus.in_data = 32'hDEAD;
        step();
        chk("settle_start", 512'(start), 512'(0));
        chk("settle_busy", 512'(busy), 512'(1));
        chk("settle_rv", 512'(result_valid), 512'(0));
        step();
        chk("busy1_busy", 512'(busy), 512'(1));
        chk("busy1_rv", 512'(result_valid), 512'(0));
        chk("busy1_result", 512'(result), 512'(0));
        bus.in_valid = 1'b0;
        step();
        chk("cap_result", 512'(result), 512'(7));
        chk("cap_rv", 512'(result_valid), 512'(1));
        chk("cap_busy", 512'(busy), 512'(0));
        chk("cap_in_ready", 512'(bus.in_ready), 512'(1));
        chk("cap_x_bus", 512'(x_bus), 512'(exp_x));
        chk("cap_w_bus", 512'(w_bus), 512'(exp_w));
        done = 1'b0;
        step();
        chk("cap_rv_pulse", 512'(result_valid), 512'(0));
        chk("cap_result_hold", 512'(result), 512'(7));
        chk("full_start_count", 512'(start_cnt - s0), 512'(1));

        // Partial load then asynchronous reset.
        for (int k = 1; k <= 9; k++) begin
            bus.in_valid = 1'b1; bus.in_data = DW'(100 + k);
            step();
        end
        bus.in_valid = 1'b0;
        chk("part_x_bus", 512'(x_bus), 512'({32'd104, 32'd103, 32'd102, 32'd101}));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_x_bus", 512'(x_bus), 512'(0));
        chk("mid_rst_w_bus", 512'(w_bus), 512'(0));
        chk("mid_rst_result", 512'(result), 512'(0));
        chk("mid_rst_in_ready", 512'(bus.in_ready), 512'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Gapped load: valid pattern 1,0,0 repeating.
        s0 = start_cnt;
        for (int k = 1; k <= 20; k++) begin
            bus.in_valid = 1'b1; bus.in_data = DW'(k);
            step();
            if (k < 20) begin
                bus.in_valid = 1'b0;
                step();
                step();
            end
        end
        chk("gap_start", 512'(start), 512'(1));
        chk("gap_x_bus", 512'(x_bus), 512'(exp_x));
        chk("gap_w_bus", 512'(w_bus), 512'(exp_w));

        // Backpressure through SETTLE and 10 BUSY cycles.
        bus.in_valid = 1'b1; bus.in_data = 32'hDEAD;
        step();
        step();
        repeat (10) step();
        chk("bp_busy", 512'(busy), 512'(1));
        chk("bp_in_ready", 512'(bus.in_ready), 512'(0));
        chk("bp_rv", 512'(result_valid), 512'(0));
        chk("bp_x_bus", 512'(x_bus), 512'(exp_x));
        chk("bp_w_bus", 512'(w_bus), 512'(exp_w));
        done = 1'b1; res_in = 32'h1234_5678;
        step();
        chk("late_result", 512'(result), 512'(32'h1234_5678));
        chk("late_rv", 512'(result_valid), 512'(1));
        chk("late_busy", 512'(busy), 512'(0));
        done = 1'b0; bus.in_valid = 1'b0;
        step();
        chk("late_rv_pulse", 512'(result_valid), 512'(0));
        chk("gap_start_count", 512'(start_cnt - s0), 512'(1));

        // Counter did not advance during backpressure: next word lands in X0.
        bus.in_valid = 1'b1; bus.in_data = 32'hA;
        step();
        bus.in_valid = 1'b0;
        exp_x[DW-1:0] = 32'hA;
        chk("next_x0", 512'(x_bus), 512'(exp_x));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
